xc_malu_issue: RTL and testbench
================================

Name: xc_malu_issue

Overview:
- Issue/retire controller directly upstream of the XCrypto multi-cycle ALU.
- Accepts one decoded multi-cycle instruction from the execute stage over a valid/ready handshake.
- Decodes its opcode into the MALU one-hot uop and pack-width strobes, and holds operands stable while the MALU iterates.
- Selects and formats the 64-bit MALU result into register writeback data, then flushes MALU state with LFSR data before accepting the next request.

Parameters:
LFSR_SEED, 32'h6A09E667, reset value of flush-data LFSR; must be non-zero.
FLUSH_RANDOM, 1, 1 = flush_data from LFSR; 0 = flush_data forced to zero.

Ports:
clock  in  1  single clock, all state on rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request valid.
req_ready  out  1  request accepted when req_valid && req_ready.
req_op  in  5  opcode, encodings in xc_malu_pkg.
req_pw  in  3  pack width: 0=32, 1=16, 2=8, 3=4, 4=2; 5-7 illegal.
req_rs1, req_rs2, req_rs3  in  32 each  source operands.
req_rd  in  5  destination register.
kill  in  1  abandon the current operation (pipeline flush/trap).
malu_rs1, malu_rs2, malu_rs3  out  32 each  registered operands to the MALU.
malu_uop  out  14  one-hot: div, divu, rem, remu, mul, mulu, mulsu, clmul, pmul, pclmul, madd, msub, macc, mmul (bit 0 = div).
malu_pw  out  5  one-hot {pw_2, pw_4, pw_8, pw_16, pw_32}.
malu_valid  out  1  MALU inputs valid.
malu_flush  out  1  MALU flush.
malu_flush_data  out  32  flush fill data.
malu_result  in  64  MALU result.
malu_ready  in  1  MALU result ready.
rsp_valid  out  1  writeback data valid.
rsp_ready  in  1  writeback stage accepts.
rsp_rd  out  5  destination register.
rsp_wide  out  1  write rd (lo) and rd+1 (hi).
rsp_lo, rsp_hi  out  32 each  writeback data.
rsp_illegal  out  1  opcode or pack width illegal; data is zero.

Behaviour:
- Clock and reset: one clock `clock`; synchronous active-high `reset`. On reset: state IDLE; lfsr=LFSR_SEED; operand/uop/pw/result registers 0; all rsp_* 0; malu_valid 0.
- malu_flush = reset || state==FLUSH.
- FSM states:
  - IDLE: req_ready = !kill. On accept, register operands, rd, decoded uop/pw and the result-select code.
    - Legal op -> ISSUE.
    - Illegal op/pw -> RESP with rsp_illegal=1 and zero data; MALU is not touched.
  - ISSUE: malu_valid=1; all malu_* inputs constant. When malu_ready is sampled high (may happen in the first ISSUE cycle), register the formatted result -> RESP.
  - RESP: rsp_valid=1 and rsp_* stable. On rsp_ready -> FLUSH; an illegal response returns -> IDLE instead.
  - FLUSH: exactly one cycle.
    - malu_flush=1; malu_valid=0.
    - Operand registers load malu_flush_data; lfsr advances.
    - Next state IDLE.
- Minimum legal-op occupancy: accept + ISSUE(n cycles) + RESP(≥1) + FLUSH = n+3 cycles.
- kill:
  - In ISSUE or RESP: go to FLUSH next cycle; no response is emitted; rsp_valid drops next cycle.
  - In IDLE: no request is accepted.
  - In FLUSH: ignored.
  - kill beats a simultaneous malu_ready or rsp_ready.
- Opcode mapping (uop; result select):
  - DIV, DIVU, REM, REMU -> div/divu/rem/remu; lo = result[31:0].
  - MUL -> mul; lo = result[31:0].
  - MULH / MULHU / MULHSU -> mul / mulu / mulsu; lo = result[63:32].
  - CLMUL -> clmul; lo = result[31:0].
  - CLMULH -> clmul; lo = result[63:32].
  - CLMULR -> clmul; lo = {result[62:32], result[31]}.
  - PMUL_L / PMUL_H, PCLMUL_L / PCLMUL_H -> pmul / pclmul; lo = [31:0] / [63:32].
  - MADD, MSUB, MACC, MMUL -> long uops; wide: lo = result[31:0], hi = result[63:32].
  - Non-wide ops: rsp_hi = 0, rsp_wide = 0.
- Pack width: only PMUL_* and PCLMUL_* use req_pw; all other ops force malu_pw = pw_32 and ignore req_pw.
- Undefined opcodes 19-31 are illegal; req_pw 5-7 is illegal for packed ops only.
- LFSR: 32-bit Galois form, taps mask 32'h80200003, shift right, feedback from bit 0. malu_flush_data = FLUSH_RANDOM ? lfsr : 0. During reset, malu_flush_data is LFSR_SEED (or 0).

Decomposition:
- xc_malu_pkg: opcode localparams, pw encodings, uop bit indices, result-select codes (LO, HI, CLMULR, WIDE), FSM state encodings (one-hot, 4 bits), LFSR taps.
- Sub-module xc_malu_issue_decode (combinational): op/pw to uop, pw, select, wide, illegal.
- The FSM, registers and LFSR stay in the top module.

Test Plan:
1. MULHU with rs1=32'hFFFFFFFF, rs2=32'h2; MALU model returns 64'h00000001_FFFFFFFE after 33 cycles -> malu_uop = mulu only; rsp_lo=1, rsp_hi=0, rsp_wide=0; flush pulse 1 cycle after rsp handshake; req_ready back in the following cycle.
2. MMUL, model result 64'h12345678_9ABCDEF0 -> rsp_wide=1, rsp_lo=32'h9ABCDEF0, rsp_hi=32'h12345678; operands held constant throughout ISSUE.
3. CLMULR with result 64'h80000001_80000000 -> rsp_lo=32'h00000003.
4. PMUL_L with req_pw=6 -> no malu_valid; rsp_illegal=1, data 0; no flush pulse.
5. kill in the 5th ISSUE cycle of DIV -> no rsp_valid; FLUSH next cycle with malu_flush_data = LFSR step 1 of LFSR_SEED; new request accepted 2 cycles after kill.
6. rsp_ready held low for 10 cycles -> rsp_* stable; req_ready=0 throughout. reset asserted mid-RESP -> next cycle rsp_valid=0, malu_flush=1 while reset is high.

Source files
------------

// File: rtl/xc_malu_pkg.sv
// Shared encodings for the XCrypto MALU issue controller: opcodes, pack widths,
// uop bit positions, result-select codes, FSM states and the flush LFSR step.
package xc_malu_pkg;

  localparam logic [4:0] OP_DIV      = 5'd0;
  localparam logic [4:0] OP_DIVU     = 5'd1;
  localparam logic [4:0] OP_REM      = 5'd2;
  localparam logic [4:0] OP_REMU     = 5'd3;
  localparam logic [4:0] OP_MUL      = 5'd4;
  localparam logic [4:0] OP_MULH     = 5'd5;
  localparam logic [4:0] OP_MULHU    = 5'd6;
  localparam logic [4:0] OP_MULHSU   = 5'd7;
  localparam logic [4:0] OP_CLMUL    = 5'd8;
  localparam logic [4:0] OP_CLMULH   = 5'd9;
  localparam logic [4:0] OP_CLMULR   = 5'd10;
  localparam logic [4:0] OP_PMUL_L   = 5'd11;
  localparam logic [4:0] OP_PMUL_H   = 5'd12;
  localparam logic [4:0] OP_PCLMUL_L = 5'd13;
  localparam logic [4:0] OP_PCLMUL_H = 5'd14;
  localparam logic [4:0] OP_MADD     = 5'd15;
  localparam logic [4:0] OP_MSUB     = 5'd16;
  localparam logic [4:0] OP_MACC     = 5'd17;
  localparam logic [4:0] OP_MMUL     = 5'd18;

  localparam logic [2:0] PW_32 = 3'd0;
  localparam logic [2:0] PW_16 = 3'd1;
  localparam logic [2:0] PW_8  = 3'd2;
  localparam logic [2:0] PW_4  = 3'd3;
  localparam logic [2:0] PW_2  = 3'd4;

  localparam int U_DIV    = 0;
  localparam int U_DIVU   = 1;
  localparam int U_REM    = 2;
  localparam int U_REMU   = 3;
  localparam int U_MUL    = 4;
  localparam int U_MULU   = 5;
  localparam int U_MULSU  = 6;
  localparam int U_CLMUL  = 7;
  localparam int U_PMUL   = 8;
  localparam int U_PCLMUL = 9;
  localparam int U_MADD   = 10;
  localparam int U_MSUB   = 11;
  localparam int U_MACC   = 12;
  localparam int U_MMUL   = 13;

  typedef enum logic [1:0] {
    SEL_LO     = 2'd0,
    SEL_HI     = 2'd1,
    SEL_CLMULR = 2'd2,
    SEL_WIDE   = 2'd3
  } sel_e;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_ISSUE = 4'b0010,
    ST_RESP  = 4'b0100,
    ST_FLUSH = 4'b1000
  } state_e;

  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  // Galois LFSR: shift right, fold the taps back in when the dropped bit is set.
  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0000_0000);
  endfunction

endpackage

// File: rtl/xc_malu_issue_decode.sv
// Combinational opcode/pack-width decode into MALU uop, pw strobes and result select.
module xc_malu_issue_decode
  import xc_malu_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [2:0]  pw,
  output logic [13:0] uop,
  output logic [4:0]  pw_oh,
  output sel_e        sel,
  output logic        illegal
);

  logic packed_s;

  // Map the opcode onto a uop bit and result select; only packed ops honour pw.
  always_comb begin
    uop      = 14'd0;
    pw_oh    = 5'b00001;
    sel      = SEL_LO;
    illegal  = 1'b0;
    packed_s = 1'b0;
    case (op)
      OP_DIV:      uop[U_DIV]   = 1'b1;
      OP_DIVU:     uop[U_DIVU]  = 1'b1;
      OP_REM:      uop[U_REM]   = 1'b1;
      OP_REMU:     uop[U_REMU]  = 1'b1;
      OP_MUL:      uop[U_MUL]   = 1'b1;
      OP_MULH:     begin uop[U_MUL]   = 1'b1; sel = SEL_HI; end
      OP_MULHU:    begin uop[U_MULU]  = 1'b1; sel = SEL_HI; end
      OP_MULHSU:   begin uop[U_MULSU] = 1'b1; sel = SEL_HI; end
      OP_CLMUL:    uop[U_CLMUL] = 1'b1;
      OP_CLMULH:   begin uop[U_CLMUL] = 1'b1; sel = SEL_HI; end
      OP_CLMULR:   begin uop[U_CLMUL] = 1'b1; sel = SEL_CLMULR; end
      OP_PMUL_L:   begin uop[U_PMUL]   = 1'b1; packed_s = 1'b1; end
      OP_PMUL_H:   begin uop[U_PMUL]   = 1'b1; packed_s = 1'b1; sel = SEL_HI; end
      OP_PCLMUL_L: begin uop[U_PCLMUL] = 1'b1; packed_s = 1'b1; end
      OP_PCLMUL_H: begin uop[U_PCLMUL] = 1'b1; packed_s = 1'b1; sel = SEL_HI; end
      OP_MADD:     begin uop[U_MADD] = 1'b1; sel = SEL_WIDE; end
      OP_MSUB:     begin uop[U_MSUB] = 1'b1; sel = SEL_WIDE; end
      OP_MACC:     begin uop[U_MACC] = 1'b1; sel = SEL_WIDE; end
      OP_MMUL:     begin uop[U_MMUL] = 1'b1; sel = SEL_WIDE; end
      default:     illegal = 1'b1;
    endcase
    if (packed_s) begin
      if (pw > PW_2) begin
        illegal = 1'b1;
      end else begin
        pw_oh = 5'b00001 << pw;
      end
    end else begin
      pw_oh = 5'b00001;
    end
    if (illegal) begin
      uop   = 14'd0;
      pw_oh = 5'b00000;
      sel   = SEL_LO;
    end else begin
      sel   = sel;
    end
  end

endmodule

// File: rtl/xc_malu_issue.sv
// Issue/retire controller in front of the XCrypto multi-cycle ALU: accepts a request,
// holds operands while the MALU iterates, formats the writeback and flushes MALU state.
module xc_malu_issue
  import xc_malu_pkg::*;
#(
  parameter logic [31:0] LFSR_SEED    = 32'h6A09E667,
  parameter bit          FLUSH_RANDOM = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_op,
  input  logic [2:0]  req_pw,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_rs3,
  input  logic [4:0]  req_rd,
  input  logic        kill,
  output logic [31:0] malu_rs1,
  output logic [31:0] malu_rs2,
  output logic [31:0] malu_rs3,
  output logic [13:0] malu_uop,
  output logic [4:0]  malu_pw,
  output logic        malu_valid,
  output logic        malu_flush,
  output logic [31:0] malu_flush_data,
  input  logic [63:0] malu_result,
  input  logic        malu_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [4:0]  rsp_rd,
  output logic        rsp_wide,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_illegal
);

  state_e      state_q, state_d;
  logic [31:0] lfsr_q, lfsr_d;
  logic [31:0] rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
  logic [13:0] uop_q, uop_d;
  logic [4:0]  pw_q, pw_d;
  sel_e        sel_q, sel_d;
  logic [4:0]  rd_q, rd_d;
  logic        malu_valid_q, malu_valid_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_wide_q, rsp_wide_d;
  logic        rsp_ill_q, rsp_ill_d;
  logic [31:0] rsp_lo_q, rsp_lo_d, rsp_hi_q, rsp_hi_d;

  logic [13:0] dec_uop_s;
  logic [4:0]  dec_pw_s;
  sel_e        dec_sel_s;
  logic        dec_ill_s;
  logic        accept_s;
  logic [31:0] fmt_lo_s, fmt_hi_s;
  logic        fmt_wide_s;

  xc_malu_issue_decode u_decode (
    .op      (req_op),
    .pw      (req_pw),
    .uop     (dec_uop_s),
    .pw_oh   (dec_pw_s),
    .sel     (dec_sel_s),
    .illegal (dec_ill_s)
  );

  assign req_ready       = (state_q == ST_IDLE) && !kill;
  assign accept_s        = req_ready && req_valid;
  assign malu_flush      = reset || (state_q == ST_FLUSH);
  // The register only holds the seed after the first reset edge, so mux it in directly.
  assign malu_flush_data = FLUSH_RANDOM ? (reset ? LFSR_SEED : lfsr_q) : 32'h0000_0000;

  assign malu_rs1    = rs1_q;
  assign malu_rs2    = rs2_q;
  assign malu_rs3    = rs3_q;
  assign malu_uop    = uop_q;
  assign malu_pw     = pw_q;
  assign malu_valid  = malu_valid_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rd      = rd_q;
  assign rsp_wide    = rsp_wide_q;
  assign rsp_lo      = rsp_lo_q;
  assign rsp_hi      = rsp_hi_q;
  assign rsp_illegal = rsp_ill_q;

  // Result formatting for the registered select code.
  always_comb begin
    fmt_lo_s   = malu_result[31:0];
    fmt_hi_s   = 32'h0000_0000;
    fmt_wide_s = 1'b0;
    case (sel_q)
      SEL_LO:     fmt_lo_s = malu_result[31:0];
      SEL_HI:     fmt_lo_s = malu_result[63:32];
      SEL_CLMULR: fmt_lo_s = {malu_result[62:32], malu_result[31]};
      SEL_WIDE:   begin fmt_hi_s = malu_result[63:32]; fmt_wide_s = 1'b1; end
      default:    fmt_lo_s = 32'h0000_0000;
    endcase
  end

  // Next-state and datapath update; kill takes priority over both handshakes.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rs3_d      = rs3_q;
    uop_d      = uop_q;
    pw_d       = pw_q;
    sel_d      = sel_q;
    rd_d       = rd_q;
    rsp_lo_d   = rsp_lo_q;
    rsp_hi_d   = rsp_hi_q;
    rsp_wide_d = rsp_wide_q;
    rsp_ill_d  = rsp_ill_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          rd_d       = req_rd;
          rsp_ill_d  = dec_ill_s;
          rsp_lo_d   = 32'h0000_0000;
          rsp_hi_d   = 32'h0000_0000;
          rsp_wide_d = 1'b0;
          if (dec_ill_s) begin
            state_d = ST_RESP;
          end else begin
            rs1_d   = req_rs1;
            rs2_d   = req_rs2;
            rs3_d   = req_rs3;
            uop_d   = dec_uop_s;
            pw_d    = dec_pw_s;
            sel_d   = dec_sel_s;
            state_d = ST_ISSUE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (kill) begin
          state_d = ST_FLUSH;
        end else if (malu_ready) begin
          rsp_lo_d   = fmt_lo_s;
          rsp_hi_d   = fmt_hi_s;
          rsp_wide_d = fmt_wide_s;
          state_d    = ST_RESP;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_RESP: begin
        if (kill) begin
          state_d = ST_FLUSH;
        end else if (rsp_ready) begin
          state_d = rsp_ill_q ? ST_IDLE : ST_FLUSH;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_FLUSH: begin
        rs1_d   = malu_flush_data;
        rs2_d   = malu_flush_data;
        rs3_d   = malu_flush_data;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Advance on entry so the FLUSH cycle presents fresh fill data.
    if ((state_d == ST_FLUSH) && (state_q != ST_FLUSH)) begin
      lfsr_d = lfsr_step(lfsr_q);
    end else begin
      lfsr_d = lfsr_q;
    end
    malu_valid_d = (state_d == ST_ISSUE);
    rsp_valid_d  = (state_d == ST_RESP);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= LFSR_SEED;
      rs1_q        <= 32'h0000_0000;
      rs2_q        <= 32'h0000_0000;
      rs3_q        <= 32'h0000_0000;
      uop_q        <= 14'd0;
      pw_q         <= 5'd0;
      sel_q        <= SEL_LO;
      rd_q         <= 5'd0;
      malu_valid_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_wide_q   <= 1'b0;
      rsp_ill_q    <= 1'b0;
      rsp_lo_q     <= 32'h0000_0000;
      rsp_hi_q     <= 32'h0000_0000;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rs3_q        <= rs3_d;
      uop_q        <= uop_d;
      pw_q         <= pw_d;
      sel_q        <= sel_d;
      rd_q         <= rd_d;
      malu_valid_q <= malu_valid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_wide_q   <= rsp_wide_d;
      rsp_ill_q    <= rsp_ill_d;
      rsp_lo_q     <= rsp_lo_d;
      rsp_hi_q     <= rsp_hi_d;
    end
  end

endmodule

// File: tb/tb_xc_malu_issue.sv
// Self-checking bench for xc_malu_issue: directed vector table, randomized ops against
// an opcode-level reference model, and hand-written kill/reset sequences.
module tb_xc_malu_issue;

  localparam logic [31:0] SEED = 32'h6A09E667;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, kill;
  logic [4:0]  req_op, req_rd;
  logic [2:0]  req_pw;
  logic [31:0] req_rs1, req_rs2, req_rs3;
  logic [31:0] malu_rs1, malu_rs2, malu_rs3, malu_flush_data;
  logic [13:0] malu_uop;
  logic [4:0]  malu_pw;
  logic        malu_valid, malu_flush, malu_ready;
  logic [63:0] malu_result;
  logic        rsp_valid, rsp_ready, rsp_wide, rsp_illegal;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_lo, rsp_hi;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] lfsr_m;

  typedef struct {
    logic [4:0]  op;
    logic [2:0]  pw;
    logic [31:0] rs1, rs2, rs3;
    logic [4:0]  rd;
    logic [63:0] res;
    int          lat;
    int          hold;
    logic [13:0] e_uop;
    logic [4:0]  e_pw;
    logic [31:0] e_lo, e_hi;
    logic        e_wide, e_ill;
  } vec_t;

  vec_t tbl[14];

  xc_malu_issue dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_pw(req_pw),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3), .req_rd(req_rd),
    .kill(kill),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
    .malu_uop(malu_uop), .malu_pw(malu_pw), .malu_valid(malu_valid),
    .malu_flush(malu_flush), .malu_flush_data(malu_flush_data),
    .malu_result(malu_result), .malu_ready(malu_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rd(rsp_rd), .rsp_wide(rsp_wide),
    .rsp_lo(rsp_lo), .rsp_hi(rsp_hi), .rsp_illegal(rsp_illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
  endfunction

  // Reference: opcode groups from the instruction set, not the decoder structure.
  function automatic vec_t model(input logic [4:0] op, input logic [2:0] pw, input logic [63:0] res);
    int uop_of[19] = '{0, 1, 2, 3, 4, 4, 5, 6, 7, 7, 7, 8, 8, 9, 9, 10, 11, 12, 13};
    vec_t v;
    bit is_packed, upper, wide;
    v.op = op; v.pw = pw; v.res = res;
    is_packed = (op >= 11) && (op <= 14);
    upper = (op == 5) || (op == 6) || (op == 7) || (op == 9) || (op == 12) || (op == 14);
    wide  = (op >= 15) && (op <= 18);
    v.e_ill  = (op > 18) || (is_packed && (pw > 4));
    v.e_uop  = 14'd0; v.e_pw = 5'd0; v.e_lo = 32'd0; v.e_hi = 32'd0; v.e_wide = 1'b0;
    if (!v.e_ill) begin
      v.e_uop  = 14'd1 << uop_of[op];
      v.e_pw   = is_packed ? (5'd1 << pw) : 5'd1;
      v.e_wide = wide;
      if (op == 10) v.e_lo = res[62:31];
      else if (upper) v.e_lo = res[63:32];
      else v.e_lo = res[31:0];
      if (wide) v.e_hi = res[63:32];
    end
    return v;
  endfunction

  task automatic apply_reset();
    reset = 1'b1; req_valid = 1'b0; kill = 1'b0; malu_ready = 1'b0; rsp_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    lfsr_m = SEED;
  endtask

  task automatic do_op(input vec_t v);
    req_valid = 1'b1; req_op = v.op; req_pw = v.pw; req_rd = v.rd;
    req_rs1 = v.rs1; req_rs2 = v.rs2; req_rs3 = v.rs3;
    #1 chk("req_ready_idle", req_ready, 1);
    tick();
    req_valid = 1'b0; req_op = 5'($urandom); req_pw = 3'($urandom); req_rd = 5'($urandom);
    req_rs1 = $urandom; req_rs2 = $urandom; req_rs3 = $urandom;
    if (v.e_ill) begin
      chk("ill_no_malu_valid", malu_valid, 0);
    end else begin
      for (int i = 1; i <= v.lat; i++) begin
        chk("issue_valid", malu_valid, 1);
        chk("issue_uop", malu_uop, v.e_uop);
        chk("issue_pw", malu_pw, v.e_pw);
        chk("issue_rs1", malu_rs1, v.rs1);
        chk("issue_rs2", malu_rs2, v.rs2);
        chk("issue_rs3", malu_rs3, v.rs3);
        chk("issue_busy", {malu_flush, req_ready, rsp_valid}, 0);
        malu_ready  = (i == v.lat);
        malu_result = (i == v.lat) ? v.res : {$urandom, $urandom};
        tick();
      end
      malu_ready = 1'b0;
    end
    for (int h = 0; h <= v.hold; h++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_rd", rsp_rd, v.rd);
      chk("rsp_lo", rsp_lo, v.e_lo);
      chk("rsp_hi", rsp_hi, v.e_hi);
      chk("rsp_wide", rsp_wide, v.e_wide);
      chk("rsp_illegal", rsp_illegal, v.e_ill);
      chk("rsp_busy", {req_ready, malu_valid, malu_flush}, 0);
      rsp_ready = (h == v.hold);
      tick();
    end
    rsp_ready = 1'b0;
    if (!v.e_ill) begin
      lfsr_m = lfsr_next(lfsr_m);
      chk("flush_pulse", {malu_flush, malu_valid, rsp_valid, req_ready}, 4'b1000);
      chk("flush_data", malu_flush_data, lfsr_m);
      tick();
      chk("flush_operand", malu_rs1, lfsr_m);
    end
    chk("back_idle", {malu_flush, req_ready, rsp_valid}, 3'b010);
  endtask

  initial begin
    req_op = 5'd0; req_pw = 3'd0; req_rd = 5'd0; req_rs1 = 32'd0; req_rs2 = 32'd0; req_rs3 = 32'd0;
    malu_result = 64'd0;
    tbl[0]  = '{5'd6,  3'd0, 32'hFFFFFFFF, 32'h2, 32'h0, 5'd5, 64'h00000001_FFFFFFFE, 33, 10,
                14'h0020, 5'h01, 32'h00000001, 32'h0, 1'b0, 1'b0};
    tbl[1]  = '{5'd18, 3'd0, 32'h11111111, 32'h22222222, 32'h33333333, 5'd6, 64'h12345678_9ABCDEF0, 4, 0,
                14'h2000, 5'h01, 32'h9ABCDEF0, 32'h12345678, 1'b1, 1'b0};
    tbl[2]  = '{5'd10, 3'd0, 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0, 5'd7, 64'h80000001_80000000, 1, 0,
                14'h0080, 5'h01, 32'h00000003, 32'h0, 1'b0, 1'b0};
    tbl[3]  = '{5'd11, 3'd6, 32'h1, 32'h2, 32'h3, 5'd8, 64'h0, 0, 0,
                14'h0, 5'h0, 32'h0, 32'h0, 1'b0, 1'b1};
    tbl[4]  = '{5'd0,  3'd0, 32'h100, 32'h7, 32'h0, 5'd9, 64'hDEAD0000_0000BEEF, 3, 1,
                14'h0001, 5'h01, 32'h0000BEEF, 32'h0, 1'b0, 1'b0};
    tbl[5]  = '{5'd12, 3'd2, 32'h01020304, 32'h05060708, 32'h0, 5'd10, 64'hCAFEF00D_01234567, 2, 0,
                14'h0100, 5'h04, 32'hCAFEF00D, 32'h0, 1'b0, 1'b0};
    tbl[6]  = '{5'd13, 3'd4, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h0, 5'd11, 64'hCAFEF00D_01234567, 1, 0,
                14'h0200, 5'h10, 32'h01234567, 32'h0, 1'b0, 1'b0};
    tbl[7]  = '{5'd8,  3'd7, 32'h3, 32'h5, 32'h0, 5'd12, 64'hAAAA5555_0F0F0F0F, 2, 0,
                14'h0080, 5'h01, 32'h0F0F0F0F, 32'h0, 1'b0, 1'b0};
    tbl[8]  = '{5'd25, 3'd0, 32'h1, 32'h1, 32'h1, 5'd13, 64'hFFFFFFFF_FFFFFFFF, 0, 1,
                14'h0, 5'h0, 32'h0, 32'h0, 1'b0, 1'b1};
    tbl[9]  = '{5'd7,  3'd3, 32'h80000000, 32'h2, 32'h0, 5'd14, 64'h87654321_00000000, 2, 0,
                14'h0040, 5'h01, 32'h87654321, 32'h0, 1'b0, 1'b0};
    tbl[10] = '{5'd17, 3'd0, 32'h6, 32'h7, 32'h8, 5'd15, 64'h0000FFFF_FFFF0000, 3, 2,
                14'h1000, 5'h01, 32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0};
    tbl[11] = '{5'd14, 3'd1, 32'h9, 32'hA, 32'h0, 5'd16, 64'h13579BDF_2468ACE0, 1, 0,
                14'h0200, 5'h02, 32'h13579BDF, 32'h0, 1'b0, 1'b0};
    tbl[12] = '{5'd3,  3'd0, 32'h17, 32'h5, 32'h0, 5'd17, 64'hFFFFFFFF_00000007, 5, 0,
                14'h0008, 5'h01, 32'h00000007, 32'h0, 1'b0, 1'b0};
    tbl[13] = '{5'd14, 3'd5, 32'h1, 32'h2, 32'h3, 5'd18, 64'h0, 0, 0,
                14'h0, 5'h0, 32'h0, 32'h0, 1'b0, 1'b1};

    apply_reset();
    reset = 1'b1;
    #1 chk("reset_flush", malu_flush, 1);
    chk("reset_flush_data", malu_flush_data, SEED);
    tick();
    chk("reset_state", {malu_valid, rsp_valid, rsp_illegal, rsp_wide}, 0);
    chk("reset_regs", {malu_rs1, malu_uop, malu_pw, rsp_lo, rsp_hi}, 0);
    reset = 1'b0;
    #1 chk("reset_release", {malu_flush, req_ready}, 2'b01);

    for (int k = 0; k < 14; k++) do_op(tbl[k]);

    for (int r = 0; r < 30; r++) begin
      vec_t v;
      v = model(5'($urandom_range(0, 22)), 3'($urandom_range(0, 7)), {$urandom, $urandom});
      v.rs1 = $urandom; v.rs2 = $urandom; v.rs3 = $urandom; v.rd = 5'($urandom);
      v.lat = $urandom_range(1, 4); v.hold = $urandom_range(0, 2);
      do_op(v);
    end

    // kill while idle blocks acceptance
    req_valid = 1'b1; req_op = 5'd4; kill = 1'b1;
    #1 chk("kill_idle_ready", req_ready, 0);
    tick();
    kill = 1'b0; req_valid = 1'b0;
    chk("kill_idle_noissue", {malu_valid, rsp_valid, malu_flush}, 0);

    // kill in 5th ISSUE cycle of DIV, racing malu_ready, after a fresh reset
    apply_reset();
    req_valid = 1'b1; req_op = 5'd0; req_pw = 3'd0; req_rs1 = 32'h64; req_rs2 = 32'h3; req_rd = 5'd2;
    tick();
    req_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk("kill_issue_valid", malu_valid, 1);
      if (i == 5) begin kill = 1'b1; malu_ready = 1'b1; malu_result = 64'h21; end
      tick();
    end
    kill = 1'b0; malu_ready = 1'b0;
    lfsr_m = lfsr_next(lfsr_m);
    chk("kill_flush", {malu_flush, malu_valid, rsp_valid}, 3'b100);
    chk("kill_flush_data", malu_flush_data, 32'hB524F330);
    chk("kill_flush_model", malu_flush_data, lfsr_m);
    tick();
    do_op(tbl[4]);

    // kill in RESP beats rsp_ready
    req_valid = 1'b1; req_op = 5'd4; req_rs1 = 32'h5; req_rd = 5'd3;
    tick();
    req_valid = 1'b0; malu_ready = 1'b1; malu_result = 64'h19;
    tick();
    malu_ready = 1'b0;
    chk("kill_resp_pre", rsp_valid, 1);
    kill = 1'b1; rsp_ready = 1'b1;
    tick();
    kill = 1'b0; rsp_ready = 1'b0;
    lfsr_m = lfsr_next(lfsr_m);
    chk("kill_resp_flush", {malu_flush, rsp_valid}, 2'b10);
    chk("kill_resp_data", malu_flush_data, lfsr_m);
    tick();
    chk("kill_resp_idle", req_ready, 1);

    // reset asserted mid-RESP
    req_valid = 1'b1; req_op = 5'd15; req_rs1 = 32'h77; req_rd = 5'd4;
    tick();
    req_valid = 1'b0;
    tick();
    malu_ready = 1'b1; malu_result = 64'h1;
    tick();
    malu_ready = 1'b0;
    for (int h = 0; h < 3; h++) begin
      chk("rst_resp_hold", {rsp_valid, rsp_wide}, 2'b11);
      tick();
    end
    reset = 1'b1;
    #1 chk("rst_resp_flush_comb", malu_flush, 1);
    tick();
    chk("rst_resp_after", {rsp_valid, malu_valid, malu_flush}, 3'b001);
    chk("rst_resp_data", malu_flush_data, SEED);
    chk("rst_resp_regs", malu_rs1, 0);
    reset = 1'b0;
    lfsr_m = SEED;
    #1 chk("rst_resp_release", {malu_flush, req_ready}, 2'b01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
